// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frames the output stream of a Sobel core. The core
// produces WIDTH values per interior row. The first value of each row is
// an unusable priming column and is discarded. Of the rest, the first is
// replaced by a zero left border and the remaining WIDTH-2 pass through
// unchanged. A zero right border ends each row. Whole zero rows are
// written above and below the interior rows, so every frame carries
// exactly WIDTH*HEIGHT pixels.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   start            frame request, honoured only while idle
//   in_rd_en         pop strobe to the core FIFO (combinational)
//   in_dout          core FIFO head, first-word-fall-through
//   in_empty         core FIFO empty
//   out_wr_en        push strobe to the frame FIFO (combinational)
//   out_din          pushed pixel, zero whenever out_wr_en is low (comb.)
//   out_full         frame FIFO full
//   busy             registered, high from start acceptance until DONE ends
//   frame_done       registered one-cycle pulse in the DONE state
module sobel_frame_ctrl #(
    parameter int unsigned WIDTH  = 720,
    parameter int unsigned HEIGHT = 540,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              in_rd_en,
    input  logic [DWIDTH-1:0] in_dout,
    input  logic              in_empty,
    output logic              out_wr_en,
    output logic [DWIDTH-1:0] out_din,
    input  logic              out_full,
    output logic              busy,
    output logic              frame_done
);

    // Counters cover the largest legal frame dimension (4095).
    localparam int unsigned CW = 12;

    localparam logic [CW-1:0] X_LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] X_ROW_LAST = CW'(WIDTH - 2);
    localparam logic [CW-1:0] Y_MID_LAST = CW'(HEIGHT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_PRIME,
        S_ROW,
        S_EDGE,
        S_BOTTOM,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] x;
    logic [CW-1:0] x_nx;
    logic [CW-1:0] y;
    logic [CW-1:0] y_nx;

    // State, counters and the two registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            x          <= x_nx;
            y          <= y_nx;
            busy       <= (state_nx != S_IDLE);
            frame_done <= (state_nx == S_DONE);
        end
    end

    // Next state, counters and FIFO strobes. Every cycle whose FIFO
    // condition is not met holds state and counters with both strobes low.
    always_comb begin
        state_nx  = state;
        x_nx      = x;
        y_nx      = y;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_din   = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    x_nx     = '0;
                    y_nx     = '0;
                    state_nx = S_TOP;
                end
            end

            // Top border row: WIDTH zero writes.
            S_TOP: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    if (x == X_LAST) begin
                        x_nx     = '0;
                        y_nx     = CW'(1);
                        state_nx = S_PRIME;
                    end else begin
                        x_nx = x + CW'(1);
                    end
                end
            end

            // Discard the priming column of the next interior row.
            S_PRIME: begin
                if (!in_empty) begin
                    in_rd_en = 1'b1;
                    x_nx     = '0;
                    state_nx = S_ROW;
                end
            end

            // Interior row: the x=0 value is replaced by the left border,
            // the rest pass through untouched.
            S_ROW: begin
                if (!in_empty && !out_full) begin
                    in_rd_en  = 1'b1;
                    out_wr_en = 1'b1;
                    out_din   = (x == '0) ? '0 : in_dout;
                    if (x == X_ROW_LAST) begin
                        x_nx     = '0;
                        state_nx = S_EDGE;
                    end else begin
                        x_nx = x + CW'(1);
                    end
                end
            end

            // Right border; y still holds the row just finished, so the
            // last interior row is the one where y has reached HEIGHT-2.
            S_EDGE: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    y_nx      = y + CW'(1);
                    x_nx      = '0;
                    state_nx  = (y < Y_MID_LAST) ? S_PRIME : S_BOTTOM;
                end
            end

            // Bottom border row: WIDTH zero writes.
            S_BOTTOM: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    if (x == X_LAST) begin
                        x_nx     = '0;
                        state_nx = S_DONE;
                    end else begin
                        x_nx = x + CW'(1);
                    end
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: a 4x3 instance for the basic
// frame, and a 4x4 instance for pass-through, stalls, ignored starts,
// back-to-back frames and reset mid-row. Core FIFO contents are src[i]=i+1
// consumed in order across frames, so each frame's interior values are
// known by hand.
module tb_sobel_frame_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic start;
    logic start3;

    // 4x4 instance
    logic       rd, wr, empty, full, busy, fd;
    logic [7:0] dout, din;
    logic       hold_empty = 1'b0;
    logic       hold_full  = 1'b0;
    logic [7:0] src [0:127];
    int         ptr = 0;
    bit         pop_fl = 1'b0;

    assign dout  = src[ptr];
    assign empty = hold_empty;
    assign full  = hold_full;

    sobel_frame_ctrl #(.WIDTH(4), .HEIGHT(4), .DWIDTH(8)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .in_rd_en(rd), .in_dout(dout), .in_empty(empty),
        .out_wr_en(wr), .out_din(din), .out_full(full),
        .busy(busy), .frame_done(fd)
    );

    // 4x3 instance, core values 10,20,30,40
    logic       rd3, wr3, empty3, busy3, fd3;
    logic [7:0] dout3, din3;
    int         ptr3 = 0;
    bit         pop3_fl = 1'b0;

    assign dout3  = (ptr3 == 0) ? 8'd10 : (ptr3 == 1) ? 8'd20 :
                    (ptr3 == 2) ? 8'd30 : (ptr3 == 3) ? 8'd40 : 8'hEE;
    assign empty3 = (ptr3 >= 4);

    sobel_frame_ctrl #(.WIDTH(4), .HEIGHT(3), .DWIDTH(8)) u_dut3 (
        .clock(clock), .reset(reset), .start(start3),
        .in_rd_en(rd3), .in_dout(dout3), .in_empty(empty3),
        .out_wr_en(wr3), .out_din(din3), .out_full(1'b0),
        .busy(busy3), .frame_done(fd3)
    );

    // Monitor: logs what fires at the coming rising edge.
    logic [7:0] wq[$];
    logic [7:0] wq3[$];
    int cyc = 0, pops = 0, pops3 = 0, fd_cnt = 0, fd3_cnt = 0;
    int last_wr = 0, last_wr3 = 0, fd_cyc = 0, fd3_cyc = 0;
    int bad_din = 0;

    always @(negedge clock) begin
        cyc++;
        if (wr) begin wq.push_back(din); last_wr = cyc; end
        else if (din !== 8'd0) bad_din++;
        if (wr3) begin wq3.push_back(din3); last_wr3 = cyc; end
        else if (din3 !== 8'd0) bad_din++;
        if (rd)  begin pops++;  pop_fl  = 1'b1; end
        if (rd3) begin pops3++; pop3_fl = 1'b1; end
        if (fd)  begin fd_cnt++;  fd_cyc  = cyc; end
        if (fd3) begin fd3_cnt++; fd3_cyc = cyc; end
    end

    always @(posedge clock) begin
        if (pop_fl)  begin ptr++;  pop_fl  = 1'b0; end
        if (pop3_fl) begin ptr3++; pop3_fl = 1'b0; end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns #1 after the negedge at which frame_done is seen high.
    task automatic wait_fd(input bit sel3, input string tag);
        int n = 0;
        @(negedge clock);
        while (((sel3 ? fd3 : fd) !== 1'b1) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(n < 400), 32'd1);
        #1;
    endtask

    task automatic wait_pops(input int target, input string tag);
        int n = 0;
        while (pops < target && n < 400) begin
            @(posedge clock);
            n++;
        end
        chk({tag, "_pop_reach"}, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int n = 0;
        while (wq.size() < target && n < 400) begin
            @(posedge clock);
            n++;
        end
        chk({tag, "_wr_reach"}, 32'(n < 400), 32'd1);
    endtask

    // Checks one 4x4 frame logged from index w0; m0..m3 are the
    // hand-computed interior pass-through values.
    task automatic chk_frame(input string tag, input int w0, input int p0,
                             input logic [7:0] m0, input logic [7:0] m1,
                             input logic [7:0] m2, input logic [7:0] m3);
        logic [7:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = 8'd0;
        exp[5] = m0; exp[6] = m1; exp[9] = m2; exp[10] = m3;
        chk({tag, "_writes"}, 32'(wq.size() - w0), 32'd16);
        chk({tag, "_pops"}, 32'(pops - p0), 32'd8);
        if (wq.size() - w0 >= 16)
            for (int i = 0; i < 16; i++)
                chk($sformatf("%s_px%0d", tag, i), 32'(wq[w0 + i]), 32'(exp[i]));
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    initial begin
        int w0, p0, f0, ws, ps;
        logic [7:0] exp3 [12];

        for (int i = 0; i < 128; i++) src[i] = 8'(i + 1);
        reset  = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(fd), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // 4x3 frame, core 10,20,30,40
        @(posedge clock); #1 start3 = 1'b1;
        @(posedge clock); #1 start3 = 1'b0;
        wait_fd(1'b1, "f43");
        exp3 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        chk("f43_writes", 32'(wq3.size()), 32'd12);
        chk("f43_pops", 32'(pops3), 32'd4);
        chk("f43_done_lat", 32'(fd3_cyc - last_wr3), 32'd1);
        if (wq3.size() >= 12)
            for (int i = 0; i < 12; i++)
                chk($sformatf("f43_px%0d", i), 32'(wq3[i]), 32'(exp3[i]));

        // Frame A: unstalled 4x4, core 1..8
        w0 = wq.size(); p0 = pops; f0 = fd_cnt;
        pulse_start();
        @(negedge clock);
        chk("A_busy_on", 32'(busy), 32'd1);
        chk("A_top_wr", 32'(wr), 32'd1);
        wait_fd(1'b0, "A");
        chk("A_done_lat", 32'(fd_cyc - last_wr), 32'd1);
        @(negedge clock);
        chk("A_done_pulse", 32'(fd), 32'd0);
        chk("A_busy_off", 32'(busy), 32'd0);
        chk("A_done_cnt", 32'(fd_cnt - f0), 32'd1);
        chk_frame("A", w0, p0, 8'd3, 8'd4, 8'd7, 8'd8);

        // Frame B: core FIFO empty for 5 cycles at ROW x=1, core 9..16
        w0 = wq.size(); p0 = pops;
        pulse_start();
        wait_pops(p0 + 2, "B");
        #1 hold_empty = 1'b1;
        ws = wq.size(); ps = pops;
        repeat (5) begin
            @(negedge clock);
            chk("B_stall_rd", 32'(rd), 32'd0);
            chk("B_stall_wr", 32'(wr), 32'd0);
        end
        chk("B_stall_wq", 32'(wq.size()), 32'(ws));
        chk("B_stall_pops", 32'(pops), 32'(ps));
        @(posedge clock); #1 hold_empty = 1'b0;
        wait_fd(1'b0, "B");
        chk_frame("B", w0, p0, 8'd11, 8'd12, 8'd15, 8'd16);

        // Frame C: output full during EDGE, then during ROW, core 17..24
        w0 = wq.size(); p0 = pops;
        pulse_start();
        wait_writes(w0 + 7, "C_edge");
        #1 hold_full = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("C_edge_wr", 32'(wr), 32'd0);
            chk("C_edge_rd", 32'(rd), 32'd0);
        end
        @(posedge clock); #1 hold_full = 1'b0;
        wait_pops(p0 + 6, "C_row");
        #1 hold_full = 1'b1;
        ws = wq.size(); ps = pops;
        repeat (4) begin
            @(negedge clock);
            chk("C_row_wr", 32'(wr), 32'd0);
            chk("C_row_rd", 32'(rd), 32'd0);
        end
        chk("C_row_pops", 32'(pops), 32'(ps));
        chk("C_row_wq", 32'(wq.size()), 32'(ws));
        @(posedge clock); #1 hold_full = 1'b0;
        wait_fd(1'b0, "C");
        chk_frame("C", w0, p0, 8'd19, 8'd20, 8'd23, 8'd24);

        // Frame D: start pulses while busy are ignored, core 25..32
        w0 = wq.size(); p0 = pops; f0 = fd_cnt;
        pulse_start();
        repeat (3) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (6) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_fd(1'b0, "D");
        chk("D_one_frame", 32'(fd_cnt - f0), 32'd1);
        chk_frame("D", w0, p0, 8'd27, 8'd28, 8'd31, 8'd32);

        // Frame E: start in the cycle right after frame_done, core 33..40
        w0 = wq.size(); p0 = pops;
        pulse_start();
        @(negedge clock);
        chk("E_busy_on", 32'(busy), 32'd1);
        chk("E_top_wr", 32'(wr), 32'd1);
        chk("E_top_din", 32'(din), 32'd0);
        wait_fd(1'b0, "E");
        chk_frame("E", w0, p0, 8'd35, 8'd36, 8'd39, 8'd40);

        // Frame F abandoned by reset at ROW x=1
        p0 = pops;
        @(negedge clock);
        pulse_start();
        wait_pops(p0 + 2, "F");
        #1 reset = 1'b1;
        #1;
        chk("F_rst_rd", 32'(rd), 32'd0);
        chk("F_rst_wr", 32'(wr), 32'd0);
        chk("F_rst_din", 32'(din), 32'd0);
        chk("F_rst_busy", 32'(busy), 32'd0);
        chk("F_rst_done", 32'(fd), 32'd0);
        ws = wq.size(); ps = pops;
        repeat (3) @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("F_quiet_wq", 32'(wq.size()), 32'(ws));
        chk("F_quiet_pops", 32'(pops), 32'(ps));
        chk("F_quiet_busy", 32'(busy), 32'd0);

        // Frame G after reset: fresh frame, core continues at 43..50
        w0 = wq.size(); p0 = pops;
        pulse_start();
        wait_fd(1'b0, "G");
        chk_frame("G", w0, p0, 8'd45, 8'd46, 8'd49, 8'd50);

        chk("din_zero_when_idle", 32'(bad_din), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 720: frame width in pixels; legal range 3..4095.
REQ-002 SHALL have parameter HEIGHT, default 540: frame height in rows; legal range 3..4095.
REQ-003 SHALL have parameter DWIDTH, default 8: gradient pixel width.
REQ-004 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: frame start request, sampled only in IDLE.
REQ-007 SHALL have port in_rd_en, output, 1: pop strobe to the sobel core output FIFO.
REQ-008 SHALL have port in_dout, input, DWIDTH: core result, first-word-fall-through, valid when in_empty=0.
REQ-009 SHALL have port in_empty, input, 1: core FIFO empty.
REQ-010 SHALL have port out_wr_en, output, 1: push strobe to the frame output FIFO.
REQ-011 SHALL have port out_din, output, DWIDTH: pixel pushed.
REQ-012 SHALL have port out_full, input, 1: output FIFO full.
REQ-013 SHALL have port busy, output, 1: high from the start acceptance until DONE is left.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse at frame end.

Function
REQ-015 States SHALL be IDLE, TOP, PRIME, ROW, EDGE, BOTTOM and DONE, with column counter x and row counter y, each sized ceil(log2(4096)) bits.
REQ-016 In IDLE with start=1, the block SHALL clear x and y and enter TOP; start in any other state SHALL be ignored.
REQ-017 TOP SHALL write 0 each cycle out_full=0, WIDTH writes total, then set y=1 and enter PRIME.
REQ-018 PRIME SHALL pop one core value without writing (discarded priming column) when in_empty=0, then enter ROW with x=0.
REQ-019 ROW at x=0 SHALL pop one core value and write 0 (left border) in the same cycle.
REQ-020 ROW at x=1..WIDTH-2 SHALL pop in_dout and write it unchanged in the same cycle.
REQ-021 After x=WIDTH-2, ROW SHALL enter EDGE.
REQ-022 EDGE SHALL write one 0 (right border) without popping.
REQ-023 On leaving EDGE, the block SHALL increment y and enter PRIME if y<HEIGHT-2, else BOTTOM.
REQ-024 BOTTOM SHALL write WIDTH zeros, then enter DONE.
REQ-025 DONE SHALL last exactly one cycle with frame_done=1, then return to IDLE.
REQ-026 A pop+write cycle SHALL fire only when in_empty=0 and out_full=0, both together.
REQ-027 A write-only cycle SHALL fire only when out_full=0.
REQ-028 A pop-only cycle SHALL fire only when in_empty=0.
REQ-029 When the required condition for a cycle is false, the block SHALL assert neither strobe and SHALL hold state and counters.
REQ-030 in_rd_en, out_wr_en and out_din SHALL be combinational from state, x, in_empty, out_full and in_dout.
REQ-031 out_din SHALL be 0 whenever out_wr_en=0.
REQ-032 Per frame, the block SHALL make exactly WIDTH*HEIGHT writes and WIDTH*(HEIGHT-2) pops.
REQ-033 Data SHALL pass through untouched: no arithmetic and no clamping.
REQ-034 busy and frame_done SHALL be registered.
REQ-035 frame_done SHALL rise on the cycle after the last BOTTOM write.

Reset
REQ-036 On reset, the block SHALL asynchronously enter IDLE.
REQ-037 On reset, the block SHALL set x=0, y=0, busy=0, frame_done=0, in_rd_en=0, out_wr_en=0 and out_din=0.
REQ-038 Reset mid-frame SHALL abandon the frame with no further strobes; the next start SHALL begin a fresh frame at TOP.

Verification
REQ-039 WIDTH=4, HEIGHT=3, core values 10,20,30,40, FIFOs never stalled -> out sequence 0,0,0,0, 0,30,40,0, 0,0,0,0; 4 pops; frame_done one cycle after the 12th write.
REQ-040 WIDTH=4, HEIGHT=4, core 1..8 -> rows 0000 / 0,3,4,0 / 0,7,8,0 / 0000; total 16 writes, 8 pops.
REQ-041 Hold in_empty=1 during ROW x=1 for 5 cycles -> no strobes, x holds; resume produces an identical sequence.
REQ-042 Hold out_full=1 during EDGE and during ROW -> no write and no pop while full; no values lost or duplicated.
REQ-043 Start pulse while busy=1 -> ignored; one frame only; start in the cycle after frame_done -> new frame begins at TOP.
REQ-044 Assert reset in ROW mid-row -> all outputs 0 asynchronously; busy=0; next start yields a complete correct frame.
